// File: rtl/prog_mod_counter_if.sv
// Control/status bundle for prog_mod_counter: the master drives the controls,
// and the counter (slave) returns its count and the event pulses.
interface prog_mod_counter_if #(
    parameter int W = 16
);
    logic         en;
    logic         clr;
    logic         dir_down;
    logic         oneshot;
    logic         start;
    logic         mod_wr;
    logic [W-1:0] mod_in;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         wrap;
    logic         busy;
    logic         done;
    logic         mod_err;

    modport master (
        output en, clr, dir_down, oneshot, start, mod_wr, mod_in, load, load_val,
        input  q, max_tick, min_tick, wrap, busy, done, mod_err
    );

    modport slave (
        input  en, clr, dir_down, oneshot, start, mod_wr, mod_in, load, load_val,
        output q, max_tick, min_tick, wrap, busy, done, mod_err
    );
endinterface

// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulus counter with prescaler, up/down, load/clear
// and a one-shot run mode; used as a tick source for timers and baud clocks.
//
// state  | meaning
// IDLE   | free-run, or one-shot waiting for start (q holds)
// RUN    | one-shot run in progress, stepping toward terminal count
// DONE   | one-shot finished; done pulses this cycle, back to IDLE next
module prog_mod_counter #(
    parameter int W         = 16,
    parameter int M_DEFAULT = 10,
    parameter int PRESCALE  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    prog_mod_counter_if.slave      bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [W-1:0]  ONE      = W'(1);
    localparam logic [W-1:0]  TWO      = W'(2);
    localparam logic [W-1:0]  M_RST    = W'(M_DEFAULT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  m_q, m_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    state_q, state_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic step;
    logic at_top;
    logic at_bot;
    logic term;

    assign at_top = (q_q == m_q - ONE);
    assign at_bot = (q_q == '0);
    assign term   = bus.dir_down ? at_bot : at_top;
    assign step   = bus.en && (pre_q == PRE_LAST);

    always_comb begin
        q_d    = q_q;
        m_d    = m_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        // DONE lasts one cycle, and leaving one-shot mode drops any run at once
        state_d = (!bus.oneshot || state_q == S_DONE) ? S_IDLE : state_q;

        if (bus.clr) begin
            q_d     = '0;
            pre_d   = '0;
            state_d = S_IDLE;
        end else if (bus.mod_wr) begin
            if (bus.mod_in >= TWO) begin
                m_d   = bus.mod_in;
                pre_d = '0;
                q_d   = bus.dir_down ? bus.mod_in - ONE : '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.load) begin
            if (bus.load_val < m_q) begin
                q_d = bus.load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.oneshot && state_q == S_IDLE && bus.start) begin
            q_d     = bus.dir_down ? m_q - ONE : '0;
            pre_d   = '0;
            state_d = S_RUN;
        end else begin
            if (bus.en) begin
                pre_d = step ? '0 : pre_q + PRE_ONE;
            end
            if (!bus.oneshot) begin
                if (step) begin
                    if (term) begin
                        q_d    = bus.dir_down ? m_q - ONE : '0;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = bus.dir_down ? q_q - ONE : q_q + ONE;
                    end
                end
            end else if (state_q == S_RUN && step) begin
                // a one-shot stops on the terminal value instead of wrapping
                if (term) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    q_d = bus.dir_down ? q_q - ONE : q_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= '0;
            m_q     <= M_RST;
            pre_q   <= '0;
            state_q <= S_IDLE;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            m_q     <= m_d;
            pre_q   <= pre_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.max_tick = at_top;
    assign bus.min_tick = at_bot;
    assign bus.wrap     = wrap_q;
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = done_q;
    assign bus.mod_err  = err_q;
endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter: two instances (prescale 1 and 4) share one stimulus
// stream and are compared each cycle against a behavioural model.
module tb_prog_mod_counter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0, clr = 1'b0, dir_down = 1'b0, oneshot = 1'b0, start = 1'b0;
    logic mod_wr = 1'b0, load = 1'b0;
    logic [W-1:0] mod_in = '0, load_val = '0;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    prog_mod_counter_if #(.W(W)) bi1 ();
    prog_mod_counter_if #(.W(W)) bi4 ();

    assign bi1.en = en;             assign bi4.en = en;
    assign bi1.clr = clr;           assign bi4.clr = clr;
    assign bi1.dir_down = dir_down; assign bi4.dir_down = dir_down;
    assign bi1.oneshot = oneshot;   assign bi4.oneshot = oneshot;
    assign bi1.start = start;       assign bi4.start = start;
    assign bi1.mod_wr = mod_wr;     assign bi4.mod_wr = mod_wr;
    assign bi1.mod_in = mod_in;     assign bi4.mod_in = mod_in;
    assign bi1.load = load;         assign bi4.load = load;
    assign bi1.load_val = load_val; assign bi4.load_val = load_val;

    prog_mod_counter #(.W(W), .M_DEFAULT(10), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bi1.slave));
    prog_mod_counter #(.W(W), .M_DEFAULT(10), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bi4.slave));

    // phase: 0 idle/free-run, 1 one-shot running, 2 one-shot just finished
    typedef struct {
        int m;
        int q;
        int pre;
        int phase;
        bit wrap;
        bit done;
        bit err;
    } ms_t;

    ms_t s1, s4;

    function automatic ms_t reset_state();
        ms_t r;
        r.m = 10; r.q = 0; r.pre = 0; r.phase = 0;
        r.wrap = 0; r.done = 0; r.err = 0;
        return r;
    endfunction

    function automatic ms_t next_state(ms_t s, int ps);
        ms_t n = s;
        bit stepping;
        int last;
        n.wrap = 0; n.done = 0; n.err = 0;
        n.phase = (!oneshot || s.phase == 2) ? 0 : s.phase;
        last = s.m - 1;
        if (clr) begin
            n.q = 0; n.pre = 0; n.phase = 0;
        end else if (mod_wr) begin
            if (int'(mod_in) >= 2) begin
                n.m = int'(mod_in); n.pre = 0;
                n.q = dir_down ? int'(mod_in) - 1 : 0;
            end else n.err = 1;
        end else if (load) begin
            if (int'(load_val) < s.m) n.q = int'(load_val);
            else n.err = 1;
        end else if (oneshot && s.phase == 0 && start) begin
            n.q = dir_down ? last : 0; n.pre = 0; n.phase = 1;
        end else begin
            stepping = en && (s.pre == ps - 1);
            if (en) n.pre = (s.pre + 1) % ps;
            if (stepping && !oneshot) begin
                if (!dir_down) begin
                    if (s.q == last) begin n.q = 0; n.wrap = 1; end
                    else n.q = s.q + 1;
                end else begin
                    if (s.q == 0) begin n.q = last; n.wrap = 1; end
                    else n.q = s.q - 1;
                end
            end else if (stepping && s.phase == 1) begin
                if ((!dir_down && s.q == last) || (dir_down && s.q == 0)) begin
                    n.phase = 2; n.done = 1;
                end else n.q = dir_down ? s.q - 1 : s.q + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 = reset_state();
            s4 = reset_state();
        end else begin
            s1 = next_state(s1, 1);
            s4 = next_state(s4, 4);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m1_q",    int'(bi1.q),   s1.q);
            check("m1_max",  int'(bi1.max_tick), int'(s1.q == s1.m - 1));
            check("m1_min",  int'(bi1.min_tick), int'(s1.q == 0));
            check("m1_wrap", int'(bi1.wrap), int'(s1.wrap));
            check("m1_busy", int'(bi1.busy), int'(s1.phase == 1));
            check("m1_done", int'(bi1.done), int'(s1.done));
            check("m1_err",  int'(bi1.mod_err), int'(s1.err));
            check("m4_q",    int'(bi4.q),   s4.q);
            check("m4_max",  int'(bi4.max_tick), int'(s4.q == s4.m - 1));
            check("m4_min",  int'(bi4.min_tick), int'(s4.q == 0));
            check("m4_wrap", int'(bi4.wrap), int'(s4.wrap));
            check("m4_busy", int'(bi4.busy), int'(s4.phase == 1));
            check("m4_done", int'(bi4.done), int'(s4.done));
            check("m4_err",  int'(bi4.mod_err), int'(s4.err));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int exp_dn[5];
        exp_dn = '{3, 2, 1, 0, 4};

        #2 reset = 1'b1;
        #1 chk_on = 1'b1;
        cyc();
        check("rst_q", int'(bi1.q), 0);
        check("rst_min", int'(bi1.min_tick), 1);
        check("rst_busy", int'(bi1.busy), 0);
        check("rst_flags", int'({bi1.wrap, bi1.done, bi1.mod_err}), 0);
        cyc();
        reset = 1'b0;

        // free-run up, M=10; the prescaled instance holds each value 4 cycles
        en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("t1_q", int'(bi1.q), i % 10);
            check("t1_wrap", int'(bi1.wrap), int'(i % 10 == 0));
            check("t1_max", int'(bi1.max_tick), int'(i % 10 == 9));
            check("t2_q4", int'(bi4.q), i / 4);
        end
        en = 1'b0;
        repeat (3) cyc();
        check("t2_frozen_q4", int'(bi4.q), 5);
        check("t2_frozen_q1", int'(bi1.q), 0);
        en = 1'b1;
        repeat (3) cyc();
        check("t2_pre_held", int'(bi4.q), 5);
        cyc();
        check("t2_pre_step", int'(bi4.q), 6);
        check("t2_q1", int'(bi1.q), 4);

        // modulus write while counting down
        dir_down = 1'b1; mod_wr = 1'b1; mod_in = 16'd5;
        cyc();
        mod_wr = 1'b0;
        check("t3_wr_q1", int'(bi1.q), 4);
        check("t3_wr_q4", int'(bi4.q), 4);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t3_dn_q", int'(bi1.q), exp_dn[i]);
            check("t3_dn_wrap", int'(bi1.wrap), int'(i == 4));
        end
        mod_wr = 1'b1; mod_in = 16'd1;
        cyc();
        mod_wr = 1'b0;
        check("t3_err", int'(bi1.mod_err), 1);
        check("t3_err_q", int'(bi1.q), 4);
        cyc();
        check("t3_err_clr", int'(bi1.mod_err), 0);
        check("t3_after_q", int'(bi1.q), 3);

        // one-shot up with M=6
        dir_down = 1'b0; oneshot = 1'b1; mod_wr = 1'b1; mod_in = 16'd6;
        cyc();
        mod_wr = 1'b0;
        check("t4_idle_q", int'(bi1.q), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t4_start_q", int'(bi1.q), 0);
        check("t4_start_busy", int'(bi1.busy), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            check("t4_run_q", int'(bi1.q), i);
            check("t4_run_busy", int'(bi1.busy), 1);
        end
        cyc();
        check("t4_end_q", int'(bi1.q), 5);
        check("t4_end_busy", int'(bi1.busy), 0);
        check("t4_done", int'(bi1.done), 1);
        check("t4_no_wrap", int'(bi1.wrap), 0);
        cyc();
        check("t4_done_once", int'(bi1.done), 0);
        check("t4_hold_q", int'(bi1.q), 5);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("t4_restart_q", int'(bi1.q), 0);
        check("t4_restart_busy", int'(bi1.busy), 1);

        // clr beats mod_wr and load; then an out-of-range load
        repeat (2) cyc();
        check("t5_pre_q", int'(bi1.q), 2);
        clr = 1'b1; mod_wr = 1'b1; mod_in = 16'd9; load = 1'b1; load_val = 16'd3;
        cyc();
        clr = 1'b0; mod_wr = 1'b0; load = 1'b0;
        check("t5_clr_q", int'(bi1.q), 0);
        check("t5_clr_busy", int'(bi1.busy), 0);
        oneshot = 1'b0; load = 1'b1; load_val = 16'd7;
        cyc();
        load = 1'b0;
        check("t5_bad_load_err", int'(bi1.mod_err), 1);
        check("t5_bad_load_q", int'(bi1.q), 0);
        load = 1'b1; load_val = 16'd5;
        cyc();
        load = 1'b0;
        check("t5_load_q", int'(bi1.q), 5);
        check("t5_load_max", int'(bi1.max_tick), 1);
        cyc();
        check("t5_wrap_q", int'(bi1.q), 0);
        check("t5_wrap", int'(bi1.wrap), 1);

        // asynchronous reset in the middle of a one-shot run
        oneshot = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        check("t6_run_q", int'(bi1.q), 3);
        check("t6_run_busy", int'(bi1.busy), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_q", int'(bi1.q), 0);
        check("t6_async_busy", int'(bi1.busy), 0);
        check("t6_async_min", int'(bi1.min_tick), 1);
        cyc();
        reset = 1'b0; oneshot = 1'b0; load = 1'b1; load_val = 16'd9;
        cyc();
        load = 1'b0;
        check("t6_m_default_err", int'(bi1.mod_err), 0);
        check("t6_m_default_q", int'(bi1.q), 9);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom % 4) != 0;
            clr      = ($urandom % 40) == 0;
            mod_wr   = ($urandom % 30) == 0;
            mod_in   = W'($urandom_range(0, 12));
            load     = ($urandom % 25) == 0;
            load_val = W'($urandom_range(0, 12));
            start    = ($urandom % 8) == 0;
            if (($urandom % 20) == 0) dir_down = ~dir_down;
            if (($urandom % 60) == 0) oneshot = ~oneshot;
            cyc();
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
